// File: rtl/fnd_scan_ctrl.sv
// Seven-segment digit scan controller: steps through enabled digit positions with a
// programmable dwell per digit and an optional dark interval between digits.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      fnd_sel,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int MAX_DWELL = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(MAX_DWELL + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [SEL_W-1:0]        sel_r, sel_s;
    logic [CNT_W-1:0]        dwell_r, dwell_s;
    logic                    frame_done_r, frame_done_s;
    logic [NUM_DIGITS-1:0]   fnd_com_s;
    logic [SEL_W-1:0]        lowest_s, next_s;

    // Lowest set mask index; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [NUM_DIGITS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = SEL_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next set mask index searching cyclically from cur+1; returns cur if nothing else is set.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] cur,
                                                  input logic [NUM_DIGITS-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        int               j;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            j = (int'(cur) + i) % NUM_DIGITS;
            if (!found && m[j]) begin
                r     = SEL_W'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    assign lowest_s = lowest_idx(digit_mask);
    assign next_s   = next_idx(sel_r, digit_mask);

    // State, digit index, dwell counter and frame pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            sel_r        <= '0;
            dwell_r      <= '0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            dwell_r      <= dwell_s;
            frame_done_r <= frame_done_s;
        end
    end

    // Next-state logic; losing enable or the whole mask always returns to IDLE first.
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        dwell_s      = dwell_r;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                dwell_s = '0;
                if (en && (digit_mask != '0)) begin
                    sel_s   = lowest_s;
                    state_s = HAS_BLANK ? BLANK : SHOW;
                end else begin
                    state_s = IDLE;
                end
            end
            BLANK: begin
                if (!en || (digit_mask == '0)) begin
                    state_s = IDLE;
                    dwell_s = '0;
                end else if (dwell_r == BLANK_LAST) begin
                    state_s = SHOW;
                    dwell_s = '0;
                end else begin
                    dwell_s = dwell_r + CNT_W'(1);
                end
            end
            SHOW: begin
                if (!en || (digit_mask == '0)) begin
                    state_s = IDLE;
                    dwell_s = '0;
                end else if (dwell_r == SHOW_LAST) begin
                    sel_s        = next_s;
                    frame_done_s = (next_s <= sel_r);
                    state_s      = HAS_BLANK ? BLANK : SHOW;
                    dwell_s      = '0;
                end else begin
                    dwell_s = dwell_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                dwell_s = '0;
            end
        endcase
    end

    // Common-line decode: only a lit, still-enabled digit pulls its line low.
    always_comb begin
        fnd_com_s = '1;
        if ((state_r == SHOW) && digit_mask[sel_r]) begin
            fnd_com_s = ~(NUM_DIGITS'(1) << sel_r);
        end else begin
            fnd_com_s = '1;
        end
    end

    assign fnd_sel    = sel_r;
    assign fnd_com    = fnd_com_s;
    assign blank      = &fnd_com_s;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: a 4-digit build with one blank cycle and a
// companion build with no blank cycles, both driven from the same stimulus.
module tb_fnd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic [1:0] sel, sel0;
    logic [3:0] com, com0;
    logic       blank, blank0, fd, fd0;
    int         nvec = 0;
    int         nmis = 0;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .fnd_sel(sel), .fnd_com(com), .blank(blank), .frame_done(fd)
    );

    fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .fnd_sel(sel0), .fnd_com(com0), .blank(blank0), .frame_done(fd0)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nmis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk4(input string tag, input logic [1:0] esel, input logic [3:0] ecom,
                        input logic eblank, input logic efd);
        chk({tag, ".sel"},   32'(sel),   32'(esel));
        chk({tag, ".com"},   32'(com),   32'(ecom));
        chk({tag, ".blank"}, 32'(blank), 32'(eblank));
        chk({tag, ".fd"},    32'(fd),    32'(efd));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] d;
        logic [3:0] ecom;
        int         ph;

        // Reset held with en=1.
        rst  = 1'b0;
        en   = 1'b1;
        mask = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk4("reset", 2'd0, 4'b1111, 1'b1, 1'b0);
        end
        rst = 1'b1;

        // Full scan, two 20-cycle frames.
        for (int k = 0; k < 40; k++) begin
            cyc();
            ph   = k % 5;
            d    = 2'((k / 5) % 4);
            ecom = (ph == 0) ? 4'b1111 : ~(4'b0001 << d);
            chk4("full", d, ecom, ph == 0, (ph == 0) && (d == 2'd0) && (k > 0));
        end

        // Reset mid-SHOW, then skip pattern 0101.
        mask = 4'b0101;
        do_reset();
        chk4("rst_mid_show", 2'd0, 4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            ph   = k % 5;
            d    = 2'(((k / 5) % 2) * 2);
            ecom = (ph == 0) ? 4'b1111 : ~(4'b0001 << d);
            chk4("skip", d, ecom, ph == 0, (ph == 0) && (d == 2'd0) && (k > 0));
        end

        // Single digit 3.
        mask = 4'b1000;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc();
            ph   = k % 5;
            ecom = (ph == 0) ? 4'b1111 : 4'b0111;
            chk4("single", 2'd3, ecom, ph == 0, (ph == 0) && (k > 0));
        end
        rst = 1'b0;
        cyc();
        chk4("rst_mid_show3", 2'd0, 4'b1111, 1'b1, 1'b0);
        rst = 1'b1;

        // Enable dropped in the 2nd SHOW cycle of digit 1.
        mask = 4'b1111;
        for (int k = 0; k < 8; k++) cyc();
        chk4("en_pre", 2'd1, 4'b1101, 1'b0, 1'b0);
        en = 1'b0;
        cyc();
        chk4("en_off", 2'd1, 4'b1111, 1'b1, 1'b0);
        en = 1'b1;
        cyc();
        chk4("reen_blank", 2'd0, 4'b1111, 1'b1, 1'b0);
        cyc();
        chk4("reen_show", 2'd0, 4'b1110, 1'b0, 1'b0);
        // Enable dropped on the dwell-expiry edge: no advance.
        for (int k = 0; k < 3; k++) cyc();
        en = 1'b0;
        cyc();
        chk4("en_expiry", 2'd0, 4'b1111, 1'b1, 1'b0);

        // Mask cleared mid-SHOW.
        en = 1'b1;
        cyc();
        cyc();
        chk4("pre_mask0", 2'd0, 4'b1110, 1'b0, 1'b0);
        mask = 4'b0000;
        cyc();
        chk4("mask0", 2'd0, 4'b1111, 1'b1, 1'b0);
        cyc();
        chk4("mask0_hold", 2'd0, 4'b1111, 1'b1, 1'b0);

        // Digit 2 cleared while digit 1 is lit.
        mask = 4'b1111;
        for (int k = 0; k < 7; k++) cyc();
        chk4("d1_lit", 2'd1, 4'b1101, 1'b0, 1'b0);
        mask = 4'b1011;
        for (int k = 7; k < 10; k++) begin
            cyc();
            chk4("d1_dwell", 2'd1, 4'b1101, 1'b0, 1'b0);
        end
        cyc();
        chk4("skip2_blank", 2'd3, 4'b1111, 1'b1, 1'b0);
        cyc();
        chk4("skip2_show", 2'd3, 4'b0111, 1'b0, 1'b0);

        // No-blank build: 16-cycle frame, never dark.
        mask = 4'b1111;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cyc();
            d    = 2'((k / 4) % 4);
            ecom = ~(4'b0001 << d);
            chk("nb.sel",   32'(sel0),   32'(d));
            chk("nb.com",   32'(com0),   32'(ecom));
            chk("nb.blank", 32'(blank0), 32'd0);
            chk("nb.fd",    32'(fd0),    32'((k % 16 == 0) && (k > 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised multiplexing controller for the seven-segment (FND) display. It steps through up to 8 digit positions and holds each for a programmable dwell time. A blanking interval between digits suppresses ghosting, and digits cleared in a runtime mask are skipped. It drives the digit-select index to the segment-data mux and the active-low common (anode) lines directly, replacing the free-running 2-bit digit counter in the stopwatch/watch display path.

## Interface
- NUM_DIGITS, 4: number of digit positions, legal 2..8
- SCAN_DIV, 100000: clk cycles a digit is lit per visit, legal ≥ 1
- BLANK_CYCLES, 2: clk cycles all digits are dark between visits, legal ≥ 0
- SEL_W, $clog2(NUM_DIGITS): width of fnd_sel (derived, do not override)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  scan enable; low forces display dark
- digit_mask  input  NUM_DIGITS  bit i = 1 includes digit i in the scan
- fnd_sel  output  SEL_W  index of current digit, to segment-data mux
- fnd_com  output  NUM_DIGITS  common lines, active-low one-hot, all ones when dark
- blank  output  1  high whenever fnd_com is all ones
- frame_done  output  1  one-cycle pulse when the scan wraps to the lowest enabled digit

## Operation
- States: IDLE, BLANK, SHOW. A dwell counter is shared by BLANK and SHOW and is cleared on every state entry.
- Reset (rst=0 at a clk edge) sets:
  - state=IDLE, fnd_sel=0, dwell counter=0
  - fnd_com = all ones, blank=1, frame_done=0
- IDLE:
  - Leaves when en=1 and digit_mask≠0.
  - On leaving, fnd_sel loads the lowest set mask index.
  - Next state is BLANK, or SHOW if BLANK_CYCLES=0.
- BLANK:
  - Display is dark.
  - After BLANK_CYCLES cycles, go to SHOW.
- SHOW:
  - fnd_com = ~(1<<fnd_sel), gated by digit_mask[fnd_sel]; if that bit is 0, fnd_com is all ones and blank=1.
  - After SCAN_DIV cycles, fnd_sel loads the next enabled index, searching cyclically from fnd_sel+1 mod NUM_DIGITS.
  - Next state is BLANK, or SHOW directly if BLANK_CYCLES=0.
- frame_done:
  - Registered, high for exactly the first cycle after a SHOW→next transition where new fnd_sel ≤ old fnd_sel.
  - A single enabled digit therefore pulses frame_done once per visit.
- en=0 in any state: next state IDLE, fnd_sel holds, frame_done=0. On re-enable, the scan restarts from the lowest enabled digit.
- digit_mask changes:
  - Mask becoming all zero in BLANK/SHOW: next state IDLE.
  - Other mask changes take effect at the next digit advance; the current dwell is not shortened.
- fnd_com, blank: decoded combinationally from registered state, fnd_sel and digit_mask only. No combinational path from en.
- fnd_sel never holds an index ≥ NUM_DIGITS.

## Timing
- Per-digit period = BLANK_CYCLES + SCAN_DIV cycles.
- Frame = k × (BLANK_CYCLES + SCAN_DIV) cycles, for k set mask bits.
- Start-up latency: first edge with rst=1, en=1 leaves IDLE. The first lit cycle follows after BLANK_CYCLES further cycles.
- Reset takes priority over all other inputs at the same edge.
- en=0 and a dwell expiry at the same edge: IDLE wins, with no advance and no frame_done.

## Test plan
Benches use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1 unless stated.
1. Reset: rst=0 for 3 cycles with en=1 → fnd_sel=0, fnd_com=4'b1111, blank=1, frame_done=0 throughout. Re-assert rst=0 mid-SHOW → same values at the next edge.
2. Full scan, mask=4'b1111, en=1:
   - fnd_com repeats 1111×1, 1110×4, 1111×1, 1101×4, 1111×1, 1011×4, 1111×1, 0111×4 (20-cycle frame).
   - frame_done high one cycle per 20, in the BLANK cycle where fnd_sel returns 0.
3. Skip, mask=4'b0101 → digits 0,2,0,2…; fnd_com 1110/1011 only; frame_done every 10 cycles.
4. Single digit, mask=4'b1000 → fnd_sel stays 3; fnd_com 1111×1, 0111×4 repeating; frame_done every 5 cycles.
5. en dropped in the 2nd SHOW cycle of digit 1 → next cycle fnd_com=1111, blank=1, fnd_sel=1 held. Re-enable → digit 0 lit after 1 BLANK cycle.
6. Mask events:
   - Mask→0 mid-SHOW: IDLE next cycle, fnd_com=1111.
   - Clearing digit 2 while digit 1 is lit: 1's dwell completes, then 3 is shown.
   - BLANK_CYCLES=0 build: no dark cycles between digits.
